// File: rtl/kmac_pkg.sv
// Shared KMAC types: encoder mode/state enums and the SP 800-185 length bound.
// Pure declarations, no logic.
package kmac_pkg;

    typedef enum logic {ENC_RIGHT = 1'b0, ENC_LEFT = 1'b1} enc_mode_t;
    typedef enum logic {ENC_IDLE = 1'b0, ENC_EMIT = 1'b1} enc_state_t;

    localparam int KMAC_MAX_ENC_BYTES = 255;

endpackage

// File: rtl/kmac_byte_len.sv
// Minimal big-endian byte count of a value (index of highest nonzero byte + 1, at least 1).
// Purely combinational, zero latency, no flow control.
module kmac_byte_len #(
    parameter int VAL_W = 64
) (
    input  logic [VAL_W-1:0] value,
    output logic [7:0]       len
);

    localparam int NB = VAL_W / 8;

    // Later (higher) byte lanes override earlier ones, so the top nonzero lane wins.
    always_comb begin
        len = 8'd1;
        for (int i = 0; i < NB; i++) begin
            if (value[8*i +: 8] != 8'h00) begin
                len = 8'(i + 1);
            end
        end
    end

endmodule

// File: rtl/kmac_encode_stream.sv
// left_encode/right_encode byte streamer: one integer in, n+1 bytes out; first byte the cycle after accept.
// Output holds data/last stable under out_ready backpressure; no new request until the last byte handshakes.
module kmac_encode_stream
    import kmac_pkg::*;
#(
    parameter int VAL_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] in_value,
    input  enc_mode_t        in_mode,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [7:0]       enc_len,
    output logic             busy
);

    localparam int NB    = VAL_W / 8;
    localparam int CNT_W = $clog2(NB + 1);

    if ((VAL_W % 8) != 0 || VAL_W < 8 || NB > KMAC_MAX_ENC_BYTES) begin : g_bad_width
        $error("kmac_encode_stream: VAL_W must be a multiple of 8 in 8..2040");
    end

    enc_state_t       state;
    enc_state_t       state_nxt;
    logic [VAL_W-1:0] value_q;
    enc_mode_t        mode_q;
    logic [7:0]       len_q;
    logic [7:0]       len_calc;
    logic [CNT_W-1:0] byte_idx;
    logic [7:0]       idx8;
    logic [7:0]       val_sel;
    logic [7:0]       value_byte;
    logic             len_slot;
    logic             last_hit;
    logic             accept;
    logic             hs;

    kmac_byte_len #(.VAL_W(VAL_W)) u_byte_len (
        .value (in_value),
        .len   (len_calc)
    );

    assign idx8     = 8'(byte_idx);
    assign last_hit = (idx8 == len_q);
    assign accept   = in_valid && in_ready;
    assign hs       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ENC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ENC_IDLE: if (accept)          state_nxt = ENC_EMIT;
            ENC_EMIT: if (hs && last_hit)  state_nxt = ENC_IDLE;
            default:                       state_nxt = ENC_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ENC_IDLE);
        out_valid = (state == ENC_EMIT);
        busy      = (state == ENC_EMIT);
        out_last  = (state == ENC_EMIT) && last_hit;
        out_data  = 8'h00;
        if (state == ENC_EMIT) begin
            out_data = len_slot ? len_q : value_byte;
        end
    end

    // RIGHT puts n after the value bytes, LEFT before; val_sel is the value byte lane (MSB first).
    always_comb begin
        len_slot   = (mode_q == ENC_RIGHT) ? last_hit : (idx8 == 8'd0);
        val_sel    = (mode_q == ENC_RIGHT) ? (len_q - 8'd1 - idx8) : (len_q - idx8);
        value_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (val_sel == 8'(i)) begin
                value_byte = value_q[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q  <= '0;
            mode_q   <= ENC_RIGHT;
            len_q    <= 8'h00;
            byte_idx <= '0;
        end else if (accept) begin
            value_q  <= in_value;
            mode_q   <= in_mode;
            len_q    <= len_calc;
            byte_idx <= '0;
        end else if (state == ENC_EMIT && hs && !last_hit) begin
            byte_idx <= byte_idx + CNT_W'(1);
        end
    end

    assign enc_len = len_q;

endmodule

// File: tb/tb_kmac_encode_stream.sv
// Scoreboard bench for kmac_encode_stream (VAL_W=64 main instance, VAL_W=16 secondary instance).
// Stimulus pushes hand-computed byte sequences; negedge monitors pop and compare.
module tb_kmac_encode_stream;
    import kmac_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic        bp_en = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_value = '0;
    enc_mode_t   in_mode = ENC_RIGHT;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic [7:0]  enc_len;
    logic        busy;

    logic        n16_in_valid = 1'b0;
    logic        n16_in_ready;
    logic [15:0] n16_in_value = '0;
    enc_mode_t   n16_in_mode = ENC_RIGHT;
    logic [7:0]  n16_out_data;
    logic        n16_out_valid;
    logic        n16_out_ready = 1'b1;
    logic        n16_out_last;
    logic [7:0]  n16_enc_len;
    logic        n16_busy;

    exp_t exp_q[$];
    exp_t exp16_q[$];

    always #5 clk = ~clk;

    kmac_encode_stream #(.VAL_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_mode   (in_mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .enc_len   (enc_len),
        .busy      (busy)
    );

    kmac_encode_stream #(.VAL_W(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (n16_in_valid),
        .in_ready  (n16_in_ready),
        .in_value  (n16_in_value),
        .in_mode   (n16_in_mode),
        .out_data  (n16_out_data),
        .out_valid (n16_out_valid),
        .out_ready (n16_out_ready),
        .out_last  (n16_out_last),
        .enc_len   (n16_enc_len),
        .busy      (n16_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Random stalls only while bp_en is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic       prev_stall = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
            prev_done  <= 1'b0;
        end else begin
            if (prev_done) begin
                chk("in_ready_after_last", in_ready, 1);
                chk("out_valid_after_last", out_valid, 0);
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            if (out_valid) begin
                chk("in_ready_while_emit", in_ready, 0);
                chk("busy_while_emit", busy, 1);
            end
            prev_done  <= 1'b0;
            prev_stall <= 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", out_data);
                end else begin
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_last", out_last, exp_q[0].last);
                    chk("enc_len", enc_len, exp_q[0].len);
                    void'(exp_q.pop_front());
                end
                prev_done <= out_last;
            end else if (out_valid) begin
                prev_stall <= 1'b1;
                prev_data  <= out_data;
                prev_last  <= out_last;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && n16_out_valid && n16_out_ready) begin
            if (exp16_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte16 actual=%0h required=none", n16_out_data);
            end else begin
                chk("out_data16", n16_out_data, exp16_q[0].data);
                chk("out_last16", n16_out_last, exp16_q[0].last);
                chk("enc_len16", n16_enc_len, exp16_q[0].len);
                void'(exp16_q.pop_front());
            end
        end
    end

    // seq is right-aligned: the final byte sits in seq[7:0], the first in seq[8*(cnt-1)+:8].
    task automatic issue(input enc_mode_t m, input logic [63:0] v, input int cnt, input logic [71:0] seq);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_before_req", in_ready, 1);
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back('{data: seq[8*(cnt-1-i) +: 8], last: (i == cnt - 1), len: 8'(cnt - 1)});
        end
        in_valid = 1'b1;
        in_mode  = m;
        in_value = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_value = ~v;
        in_mode  = enc_mode_t'(~m);
    endtask

    task automatic drain(input int cnt);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        chk("enc_len_hold", enc_len, cnt - 1);
    endtask

    task automatic req(input enc_mode_t m, input logic [63:0] v, input int cnt, input logic [71:0] seq);
        issue(m, v, cnt, seq);
        drain(cnt);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 8'h00);
        chk({tag, "_enc_len"}, enc_len, 8'h00);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_vals("reset");
        chk("reset_in_ready16", n16_in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        reset_vals("post_reset");

        req(ENC_RIGHT, 64'd0, 2, 72'h0001);
        req(ENC_RIGHT, 64'd256, 3, 72'h010002);
        req(ENC_LEFT, 64'd168, 2, 72'h01A8);
        req(ENC_LEFT, 64'd0, 2, 72'h0100);
        req(ENC_RIGHT, 64'hFFFF_FFFF_FFFF_FFFF, 9, 72'hFFFF_FFFF_FFFF_FFFF_08);
        req(ENC_LEFT, 64'h0100_0000_0000_0000, 9, 72'h08_0100_0000_0000_0000);
        req(ENC_RIGHT, 64'h80, 2, 72'h8001);

        bp_en = 1'b1;
        req(ENC_LEFT, 64'h12_3456, 4, 72'h0312_3456);
        req(ENC_RIGHT, 64'h0A_0B0C, 4, 72'h0A0B_0C03);
        bp_en = 1'b0;

        // 16-bit instance: x=0x0100 right-encoded.
        @(negedge clk);
        exp16_q.push_back('{data: 8'h01, last: 1'b0, len: 8'd2});
        exp16_q.push_back('{data: 8'h00, last: 1'b0, len: 8'd2});
        exp16_q.push_back('{data: 8'h02, last: 1'b1, len: 8'd2});
        n16_in_valid = 1'b1;
        n16_in_mode  = ENC_RIGHT;
        n16_in_value = 16'h0100;
        @(posedge clk);
        #1;
        n16_in_valid = 1'b0;
        n16_in_value = 16'hFFFF;
        for (int i = 0; i < 100 && exp16_q.size() != 0; i++) @(negedge clk);
        if (exp16_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain16_timeout actual=%0d required=0", exp16_q.size());
            exp16_q.delete();
        end

        // Abort mid-encoding after two bytes have been taken.
        issue(ENC_RIGHT, 64'h0A_0B0C, 4, 72'h0A0B_0C03);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        reset_vals("mid_reset");
        chk("mid_reset_pending", exp_q.size(), 2);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_vals("held_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_abort_idle", out_valid, 0);
        req(ENC_LEFT, 64'd1, 2, 72'h0101);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
